// File: rtl/fp_collect_pkg.sv
// Shared definitions for the floating-point result collector.
// Flag bit positions, the 36-bit FIFO entry layout and default sizing.
package fp_collect_pkg;

  localparam int FLAG_INF     = 0;
  localparam int FLAG_NEG_INF = 1;
  localparam int FLAG_NAN     = 2;
  localparam int FLAG_ERR     = 3;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_LAT   = 2;

  typedef struct packed {
    logic [3:0]  flags;
    logic [31:0] result;
  } entry_t;

  // Pack the adder's registered sum and flag bits into one FIFO entry.
  function automatic entry_t makeEntry(
    input logic [31:0] result,
    input logic        inf,
    input logic        negInf,
    input logic        nan,
    input logic        err
  );
    entry_t e;
    e.result              = result;
    e.flags               = '0;
    e.flags[FLAG_INF]     = inf;
    e.flags[FLAG_NEG_INF] = negInf;
    e.flags[FLAG_NAN]     = nan;
    e.flags[FLAG_ERR]     = err;
    return e;
  endfunction

  // An entry counts as an error result when either ERR or NAN is raised.
  function automatic logic isErrorEntry(input entry_t e);
    return e.flags[FLAG_ERR] | e.flags[FLAG_NAN];
  endfunction

endpackage

// File: rtl/fp_collect_fifo.sv
// Result FIFO: DEPTH entries of 36 bits with a registered head entry.
// The head register always holds the oldest stored entry, so the consumer
// sees data straight from a flop. DEPTH must be a power of two.
module fp_collect_fifo
  import fp_collect_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  entry_t                   i_data,
  input  logic                     i_pop,
  output logic                     o_valid,
  output entry_t                   o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          r_mem [DEPTH];
  entry_t          r_head;
  logic [PW-1:0]   r_rdPtr;
  logic [PW-1:0]   r_wrPtr;
  logic [CW-1:0]   r_count;

  logic            w_pop;
  logic            w_push;
  logic [PW-1:0]   w_rdNext;
  logic [CW-1:0]   w_countAfterPop;

  // Qualify pop/push and work out where the read pointer lands after this edge.
  always_comb begin
    w_pop           = i_pop & (r_count != '0);
    w_push          = i_push & ((r_count != CW'(DEPTH)) | w_pop);
    w_rdNext        = w_pop ? r_rdPtr + 1'b1 : r_rdPtr;
    w_countAfterPop = r_count - CW'(w_pop);
  end

  // Storage array; contents are only ever read after being written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Pointers wrap naturally at DEPTH; occupancy tracks push minus pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      r_rdPtr <= w_rdNext;
      r_count <= w_countAfterPop + CW'(w_push);
    end
  end

  // Head register: next stored entry, or the incoming one when it becomes the oldest.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head <= '0;
    end else if (w_countAfterPop != '0) begin
      r_head <= r_mem[w_rdNext];
    end else if (w_push) begin
      r_head <= i_data;
    end
  end

  assign o_valid = (r_count != '0);
  assign o_head  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/fp_result_collector.sv
// Collects registered results of a fixed-latency FP adder into a FIFO.
// A LAT-deep valid tracker follows each accepted operation; credits
// (stored + in flight) bound issue so a push never meets a full FIFO.
// Optional error statistics are enabled with macro FP_COLLECT_STATS_EN.
module fp_result_collector
  import fp_collect_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int LAT   = DEFAULT_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] result_reg,
  input  logic        INF_reg,
  input  logic        NEG_INF_reg,
  input  logic        NAN_reg,
  input  logic        ERR_reg,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_flags,
  output logic        drop_sticky,
  output logic [15:0] err_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [LAT-1:0] r_track;
  logic           r_drop;

  logic           w_accept;
  logic           w_push;
  logic           w_pop;
  logic           w_fifoValid;
  entry_t         w_pushEntry;
  entry_t         w_head;
  logic [CW-1:0]  w_count;
  logic [7:0]     w_credUsed;

  // Credits in use are stored entries plus operations still in the adder.
  always_comb begin
    w_credUsed = 8'(w_count);
    for (int i = 0; i < LAT; i++) begin
      w_credUsed = w_credUsed + 8'(r_track[i]);
    end
    in_ready = (w_credUsed < 8'(DEPTH)) | ~rst;
    w_accept = in_valid & in_ready;
  end

  // Valid shift register that mirrors the adder pipeline.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_track <= '0;
    end else begin
      r_track[0] <= w_accept;
      for (int i = 1; i < LAT; i++) begin
        r_track[i] <= r_track[i-1];
      end
    end
  end

  assign w_push      = r_track[LAT-1];
  assign w_pushEntry = makeEntry(result_reg, INF_reg, NEG_INF_reg, NAN_reg, ERR_reg);

  // Remember any issue attempted while no credit was available.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_drop <= 1'b0;
    end else if (in_valid && !in_ready) begin
      r_drop <= 1'b1;
    end
  end

  fp_collect_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_pushEntry),
    .i_pop   (w_pop),
    .o_valid (w_fifoValid),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign out_valid   = rst & w_fifoValid;
  assign out_data    = rst ? w_head.result : '0;
  assign out_flags   = rst ? w_head.flags  : '0;
  assign drop_sticky = rst & r_drop;
  assign w_pop       = out_valid & out_ready;

`ifdef FP_COLLECT_STATS_EN
  logic [15:0] r_errCount;

  // Saturating count of pushed results flagged ERR or NAN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_errCount <= '0;
    end else if (w_push && isErrorEntry(w_pushEntry) && (r_errCount != 16'hFFFF)) begin
      r_errCount <= r_errCount + 16'd1;
    end
  end

  assign err_count = rst ? r_errCount : '0;
`else
  assign err_count = '0;
`endif

endmodule
